// File: rtl/scan_request_loader.sv
// Assembles 24 template words and a 64-bit threshold from a word stream and issues a start strobe.
// Optional frame checksum word enabled by SCAN_REQUEST_CHECKSUM_EN.
module scan_request_loader (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_abort,
    input  logic        busy,
    output logic        start,
    output logic [31:0] blobby [24],
    output logic [63:0] threshold,
    output logic        error
);

    typedef enum logic [1:0] {COLLECT, PENDING, FIRE} state_t;

`ifdef SCAN_REQUEST_CHECKSUM_EN
    localparam logic [4:0] LAST = 5'd26;
`else
    localparam logic [4:0] LAST = 5'd25;
`endif

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] stage [24];
    logic [63:0] stage_thr;

`ifdef SCAN_REQUEST_CHECKSUM_EN
    logic [31:0] acc;
    logic        err;
    assign error = err;
`else
    assign error = 1'b0;
`endif

    assign in_ready = rstn && (state == COLLECT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= COLLECT;
            cnt       <= '0;
            start     <= 1'b0;
            threshold <= '0;
            for (int unsigned i = 0; i < 24; i++) begin
                blobby[i] <= '0;
            end
`ifdef SCAN_REQUEST_CHECKSUM_EN
            acc <= '0;
            err <= 1'b0;
`endif
        end else begin
            start <= 1'b0;
`ifdef SCAN_REQUEST_CHECKSUM_EN
            err   <= 1'b0;
`endif
            case (state)
                COLLECT: begin
                    if (in_abort) begin
                        cnt <= '0;
`ifdef SCAN_REQUEST_CHECKSUM_EN
                        acc <= '0;
`endif
                    end else if (in_valid) begin
                        if (cnt < 5'd24) begin
                            stage[cnt] <= in_data;
                        end else if (cnt == 5'd24) begin
                            stage_thr[31:0] <= in_data;
                        end else if (cnt == 5'd25) begin
                            stage_thr[63:32] <= in_data;
                        end
                        if (cnt == LAST) begin
                            cnt <= '0;
`ifdef SCAN_REQUEST_CHECKSUM_EN
                            acc <= '0;
                            if (in_data == acc) begin
                                state <= PENDING;
                            end else begin
                                err <= 1'b1;
                            end
`else
                            state <= PENDING;
`endif
                        end else begin
                            cnt <= cnt + 5'd1;
`ifdef SCAN_REQUEST_CHECKSUM_EN
                            acc <= acc ^ in_data;
`endif
                        end
                    end
                end
                PENDING: begin
                    // Outputs only change here, so they stay stable between requests.
                    if (in_abort) begin
                        state <= COLLECT;
                    end else if (!busy) begin
                        state     <= FIRE;
                        start     <= 1'b1;
                        blobby    <= stage;
                        threshold <= stage_thr;
                    end
                end
                FIRE: begin
                    state <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_request_loader.sv
// Scoreboard bench for scan_request_loader: driver queues expected requests, a monitor checks start/error.
// Honours SCAN_REQUEST_CHECKSUM_EN the same way as the design.
module tb_scan_request_loader;

    logic        clk;
    logic        rstn;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_abort;
    logic        busy;
    logic        start;
    logic [31:0] blobby [24];
    logic [63:0] threshold;
    logic        error;

    scan_request_loader dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_abort  (in_abort),
        .busy      (busy),
        .start     (start),
        .blobby    (blobby),
        .threshold (threshold),
        .error     (error)
    );

    typedef struct packed {
        logic [767:0] b;
        logic [63:0]  t;
        logic [31:0]  cyc;
    } exp_t;

`ifdef SCAN_REQUEST_CHECKSUM_EN
    localparam int unsigned PERIOD = 29;
`else
    localparam int unsigned PERIOD = 28;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;
    exp_t        sb_q [$];
    int unsigned err_q [$];
    int unsigned st_q [$];
    logic [31:0] fw [26];
    logic [767:0] cur_b = '0;
    logic [63:0]  cur_t = '0;
    logic         prev_start = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [767:0] pack_dut();
        logic [767:0] r;
        for (int i = 0; i < 24; i++) r[i*32 +: 32] = blobby[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on start/error and checks output stability otherwise.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (start === 1'b1) begin
                checks++;
                st_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected: got start=1 want no start (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("FAIL start_cycle: got %0d want %0d", cyc, e.cyc);
                    end
                    checks++;
                    if (pack_dut() !== e.b) begin
                        errors++;
                        $display("FAIL blobby: got %h want %h", pack_dut(), e.b);
                    end
                    checks++;
                    if (threshold !== e.t) begin
                        errors++;
                        $display("FAIL threshold: got %h want %h", threshold, e.t);
                    end
                    cur_b = e.b;
                    cur_t = e.t;
                end
                checks++;
                if (prev_start) begin
                    errors++;
                    $display("FAIL start_twice: got start high two cycles want single pulse (cycle %0d)", cyc);
                end
            end else begin
                checks++;
                if (pack_dut() !== cur_b || threshold !== cur_t) begin
                    errors++;
                    $display("FAIL hold: got thr %h want %h, blobby %h want %h", threshold, cur_t, pack_dut(), cur_b);
                end
            end
            if (error === 1'b1) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL error_unexpected: got error=1 want 0 (cycle %0d)", cyc);
                end else begin
                    int unsigned ec;
                    ec = err_q.pop_front();
                    if (ec != cyc) begin
                        errors++;
                        $display("FAIL error_cycle: got %0d want %0d", cyc, ec);
                    end
                end
                checks++;
                if (start === 1'b1) begin
                    errors++;
                    $display("FAIL error_and_start: got both high want exclusive");
                end
            end
            prev_start = (start === 1'b1);
        end
    end

    // Called at a negedge; returns k = index of the edge that takes the word.
    task automatic send_word(input logic [31:0] d, output int unsigned k);
        int unsigned n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_timeout: got in_ready=%b want 1", in_ready);
        end
        k = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // mode 0: normal, 1: corrupt checksum, 2: abort while pending
    task automatic send_frame(input int unsigned hold, input int unsigned mode);
        int unsigned k;
        logic [31:0] x;
        exp_t e;
        x = '0;
        busy = (hold > 0) || (mode == 2);
        for (int i = 0; i < 26; i++) begin
            send_word(fw[i], k);
            x ^= fw[i];
        end
`ifdef SCAN_REQUEST_CHECKSUM_EN
        send_word((mode == 1) ? (x ^ 32'h0000_0100) : x, k);
`endif
        if (mode == 1) begin
            err_q.push_back(k + 1);
        end else if (mode == 0) begin
            for (int i = 0; i < 24; i++) e.b[i*32 +: 32] = fw[i];
            e.t   = {fw[25], fw[24]};
            e.cyc = k + 2 + hold;
            sb_q.push_back(e);
        end
        if (mode == 2) begin
            in_abort = 1'b1;
            @(negedge clk);
            in_abort = 1'b0;
            busy     = 1'b0;
            chk("ready_after_pend_abort", {63'd0, in_ready}, 64'd1);
        end else if (hold > 0) begin
            for (int unsigned j = 0; j < hold; j++) begin
                chk("ready_low_pending", {63'd0, in_ready}, 64'd0);
                @(negedge clk);
            end
            busy = 1'b0;
        end
    endtask

    task automatic fill(input logic [31:0] base, input logic [31:0] t0, input logic [31:0] t1);
        for (int i = 0; i < 24; i++) fw[i] = base + 32'(i);
        fw[24] = t0;
        fw[25] = t1;
    endtask

    initial begin
        int unsigned k;
        int unsigned n0;
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_abort = 1'b0;
        busy     = 1'b0;

        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
            chk("reset_start", {63'd0, start}, 64'd0);
            chk("reset_error", {63'd0, error}, 64'd0);
        end
        chk("reset_threshold", threshold, 64'd0);
        chk("reset_blobby23", {32'd0, blobby[23]}, 64'd0);
        in_valid = 1'b0;
        rstn     = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

        // basic frame
        fill(32'h1000_0000, 32'h89AB_CDEF, 32'h0123_4567);
        send_frame(0, 0);
        repeat (3) @(negedge clk);
        chk("basic_threshold", threshold, 64'h0123_4567_89AB_CDEF);
        chk("basic_blobby5", {32'd0, blobby[5]}, 64'h1000_0005);

        // busy hold-off for 10 cycles
        fill(32'h3000_0000, 32'h0BAD_F00D, 32'hCAFE_BABE);
        send_frame(10, 0);
        repeat (3) @(negedge clk);

        // abort after 10 words with a word offered in the abort cycle
        for (int i = 0; i < 10; i++) send_word(32'h4444_0000 + 32'(i), k);
        in_abort = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        in_abort = 1'b0;
        in_valid = 1'b0;
        fill(32'h5000_0000, 32'h5555_0001, 32'h5555_0002);
        send_frame(0, 0);
        repeat (3) @(negedge clk);

        // abort while pending: no start, outputs unchanged
        fill(32'h6000_0000, 32'h6666_0001, 32'h6666_0002);
        send_frame(0, 2);
        repeat (4) @(negedge clk);

        // back-to-back frames
        n0 = st_q.size();
        fill(32'h7100_0000, 32'h7100_AAAA, 32'h7100_BBBB);
        send_frame(0, 0);
        fill(32'h7200_0000, 32'h7200_AAAA, 32'h7200_BBBB);
        send_frame(0, 0);
        fill(32'h7300_0000, 32'h7300_AAAA, 32'h7300_BBBB);
        send_frame(0, 0);
        repeat (4) @(negedge clk);
        chk("b2b_count", 64'(st_q.size()), 64'(n0 + 3));
        if (st_q.size() >= n0 + 3) begin
            chk("b2b_gap1", 64'(st_q[n0+1] - st_q[n0]), 64'(PERIOD));
            chk("b2b_gap2", 64'(st_q[n0+2] - st_q[n0+1]), 64'(PERIOD));
        end
        chk("b2b_final_thr", threshold, 64'h7300_BBBB_7300_AAAA);

`ifdef SCAN_REQUEST_CHECKSUM_EN
        fill(32'h8000_0000, 32'h8888_0001, 32'h8888_0002);
        send_frame(0, 1);
        repeat (3) @(negedge clk);
        chk("ck_bad_thr_kept", threshold, 64'h7300_BBBB_7300_AAAA);
        send_frame(0, 0);
        repeat (3) @(negedge clk);
        chk("ck_good_thr", threshold, 64'h8888_0002_8888_0001);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("err_q_empty", 64'(err_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_request_loader.md
# scan_request_loader

Upstream feeder for the SHA3 scan request bus. It accepts a 32-bit valid/ready word stream from the host side and assembles 24 block-template words plus a 64-bit threshold. When the downstream scanner is not busy, it issues a single-cycle `start`. It drives the `start`, `blobby[24]` and `threshold` inputs of the request-bus packer, and holds them stable between requests.

## Interface
- Parameters: none. Frame length is fixed: 24 template words + 2 threshold words (+1 checksum word, see Configuration).
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `in_data`  in  32  incoming frame word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts a word; a handshake is `in_valid && in_ready` at a rising edge.
- `in_abort`  in  1  discard the partial or pending frame.
- `busy`  in  1  downstream scanner busy; `start` is withheld while high.
- `start`  out  1  one-cycle request strobe.
- `blobby`  out  32×24  block template, unpacked `[24]`.
- `threshold`  out  64  scan threshold.
- `error`  out  1  one-cycle checksum-failure strobe.

## Operation
- **Frame word order:**
  - words 0..23 → `blobby[0..23]`
  - word 24 → `threshold[31:0]`
  - word 25 → `threshold[63:32]`
- **Staging:** words are written into staging registers. Output registers (`blobby`, `threshold`) are loaded from staging only on the FIRE edge, so outputs never change mid-request.
- **States:**
  - COLLECT: `in_ready=1`; 5-bit word counter `cnt`. Handshake on the last word (`cnt==25`) → PENDING, `cnt←0`.
  - PENDING: `in_ready=0`. If `busy==0` → FIRE; if `busy==1`, stay.
  - FIRE: `start=1` for exactly one cycle; outputs hold the new frame. Next state → COLLECT.
- **`in_abort`:**
  - In COLLECT: `cnt←0`; any word handshaken in the same cycle is dropped (abort wins).
  - In PENDING: frame discarded, → COLLECT. Output registers are unchanged.
  - In FIRE: ignored; `start` is still issued.
- **`busy` sampling:** `busy` is sampled only in PENDING. Changes of `busy` during FIRE or COLLECT have no effect.
- **Reset (`rstn==0` at an edge):**
  - state → COLLECT, `cnt=0`
  - `start=0`, `error=0`, all `blobby` words `=0`, `threshold=0`
  - any partial or pending frame is lost
  - `in_ready` is forced to 0 while `rstn` is low.

## Timing
- Last-word handshake at edge N:
  - cycle N+1: PENDING.
  - if `busy==0` in N+1: `start=1` and new outputs in cycle N+2.
  - cycle N+3: COLLECT, `in_ready=1`.
- Minimum latency from last handshake to `start` is 2 cycles.
- With continuous `in_valid` and `busy==0`, a request completes every 28 cycles (26 data + PENDING + FIRE); 29 cycles with checksum.
- `start` is never high on two consecutive cycles.
- `busy` high for K cycles in PENDING delays `start` by K cycles.
- `error` and `start` are mutually exclusive.

## Configuration
- Macro: `SCAN_REQUEST_CHECKSUM_EN`.
- **Defined:**
  - Frame carries a 27th word: the XOR of words 0..25.
  - On its handshake, the block compares it against a running XOR accumulator, which is cleared at frame start, on abort and on reset.
  - Match → PENDING.
  - Mismatch → `error=1` for one cycle, → COLLECT, no `start`, outputs unchanged.
- **Undefined:**
  - Frame is 26 words.
  - `error` is tied to 0.
  - No accumulator logic is present.

## Test plan
- **Reset:** hold `rstn=0` for 3 cycles with `in_valid=1` → `in_ready=0`, `start=0`, `error=0`, all outputs 0. Cycle after release → `in_ready=1`.
- **Basic frame:** send `0x1000_0000+i` for i=0..23, then `0x89ABCDEF`, `0x01234567`, with `busy=0` → `start` high exactly 2 cycles after the last handshake. `blobby[i]=0x1000_0000+i`, `threshold=0x01234567_89ABCDEF`.
- **Busy hold-off:** as above with `busy=1` for 10 cycles after the last handshake → `in_ready=0` throughout, `start` in the cycle after the PENDING cycle where `busy` is seen 0. Outputs keep the previous frame until that edge.
- **Abort:** abort after 10 words, with a word offered in the abort cycle → that word is dropped. The next 26 words alone form the request; stale words never appear on the outputs.
- **Back-to-back:** 3 frames with constant `in_valid` and `busy=0` → `start` pulses 28 cycles apart. Outputs are stable between pulses and match frames 1, 2, 3 in order.
- **Checksum** (`SCAN_REQUEST_CHECKSUM_EN`):
  - frame with a wrong 27th word → one-cycle `error`, no `start`, previous outputs retained.
  - the same frame with the correct XOR → `start` and new outputs.
